ysyx_23060208_sram_rd_arbiter: RTL and testbench
================================================

# ysyx_23060208_sram_rd_arbiter

Two-master read arbiter that shares the single instruction/data SRAM read port between the IFU (instruction fetch) and the LSU (load path). Sits between both fetch/load units and the SRAM model. Accepts AXI-lite-style AR/R handshakes from each master and forwards one transaction at a time to the SRAM. Arbitration is round-robin under contention, so neither master can starve the other.

## Interface
Parameters:
- DATA_WIDTH, 32, width of address and read data on every channel
- RESP_WIDTH, 2, width of read response
Ports:
- clk  in  1  single clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- ifu_araddr  in  DATA_WIDTH  IFU read address; held stable while ifu_arvalid=1
- ifu_arvalid  in  1  IFU read request
- ifu_arready  out  1  IFU address accepted
- ifu_rdata  out  DATA_WIDTH  read data; equals sram_rdata, meaningful only with ifu_rvalid
- ifu_rresp  out  RESP_WIDTH  read response; equals sram_rresp
- ifu_rvalid  out  1  IFU read data valid
- ifu_rready  in  1  IFU ready for data
- lsu_araddr, lsu_arvalid, lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid, lsu_rready: same directions, widths and meanings as the ifu_* ports, for the LSU
- sram_araddr  out  DATA_WIDTH  forwarded address of the granted master
- sram_arvalid  out  1  forwarded request
- sram_arready  in  1  SRAM address ready
- sram_rdata  in  DATA_WIDTH  SRAM read data
- sram_rresp  in  RESP_WIDTH  SRAM read response
- sram_rvalid  in  1  SRAM data valid
- sram_rready  out  1  forwarded data ready

## Operation
- State machine: IDLE, ADDR, DATA. Registers: state, grant (0=IFU, 1=LSU), last (last granted master).
- IDLE: if exactly one arvalid, grant that master. If both, grant the master != last. If none, stay. Any grant -> ADDR, with grant and last updated on the same edge.
- ADDR: sram_arvalid=1, sram_araddr=granted araddr. Granted arready=sram_arready (combinational). On sram_arvalid & sram_arready -> DATA.
- DATA: sram_rready=granted rready; granted rvalid=sram_rvalid. On sram_rvalid & sram_rready -> IDLE.
- The non-granted master sees arready=0 and rvalid=0 at all times. Its request stays pending and is not dropped.
- In IDLE, sram_arvalid=0, sram_rready=0, and both arready/rvalid are 0.
- Only one transaction is outstanding at a time. No address buffering: each master must hold araddr/arvalid until its handshake completes.
- rdata/rresp are broadcast to both masters. The rvalid gating alone identifies the owner.
- A master that drops arvalid while in ADDR is a protocol violation. Behaviour in that case is undefined, but the FSM must not lock up: it completes the SRAM transaction.

## Timing
- Reset (async, immediate): state=IDLE, last=IFU (so the first contention grants LSU), grant=IFU. All valid/ready outputs are 0 while rst=1 and in the first cycle after release.
- Arbitration costs 1 cycle: the earliest ifu/lsu_arready is the cycle after arvalid is seen in IDLE.
- Minimum transaction: 3 cycles (IDLE, ADDR with sram_arready=1, DATA with sram_rvalid&rready=1). Back-to-back transactions therefore have one idle cycle between them.
- The DATA->IDLE transition and a new request arriving in the same cycle: the new request is arbitrated in the following IDLE cycle. There is no grant straight from DATA.
- SRAM stalls (sram_arready=0 or sram_rvalid=0) hold state indefinitely. Master stalls (rready=0) hold DATA and keep rvalid asserted.
- Reset asserted mid-ADDR/DATA aborts the transaction with no response to the master. The SRAM shares rst and is reset too.

## Test plan
- Single IFU read: ifu_araddr=0x8000_0000, SRAM returns 0x0000_0413 with one-cycle latency. ifu_arready is high in cycle 2 and ifu_rvalid with data 0x0000_0413 is seen. lsu_arready and lsu_rvalid stay 0.
- Simultaneous ifu/lsu arvalid right after reset (lsu_araddr=0x8000_1000). LSU is granted first and completes, then IFU is granted. Order on sram_araddr is 0x8000_1000, then 0x8000_0000.
- Both requesting continuously for 6 transactions: grants alternate LSU, IFU, LSU, IFU, LSU, IFU, with no starvation.
- ifu_rready held 0 for 4 cycles in DATA: ifu_rvalid stays 1 and rdata stays stable. The FSM leaves DATA only on the cycle rready=1. A pending LSU request is not granted until then.
- sram_arready held 0 for 5 cycles: state stays ADDR and granted arready=0. It completes normally afterwards.
- rst pulsed during DATA: all valid/ready outputs go 0 immediately. After release, a fresh IFU request completes with the 3-cycle minimum latency.

Source files
------------

// File: rtl/ysyx_23060208_sram_rd_arbiter.sv
// ysyx_23060208_sram_rd_arbiter
// Shares the single SRAM read port between the instruction-fetch unit (IFU)
// and the load/store unit (LSU). One AR/R transaction is in flight at a time.
// Simultaneous requests are resolved round-robin against the last granted master.
module ysyx_23060208_sram_rd_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    // IFU read channel
    input  logic [DATA_WIDTH-1:0] ifu_araddr,
    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic [RESP_WIDTH-1:0] ifu_rresp,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,

    // LSU read channel
    input  logic [DATA_WIDTH-1:0] lsu_araddr,
    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic [RESP_WIDTH-1:0] lsu_rresp,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,

    // Shared SRAM read port
    output logic [DATA_WIDTH-1:0] sram_araddr,
    output logic                  sram_arvalid,
    input  logic                  sram_arready,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    input  logic [RESP_WIDTH-1:0] sram_rresp,
    input  logic                  sram_rvalid,
    output logic                  sram_rready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Master encoding used by r_grant / r_last
    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    state_t r_state;
    logic   r_grant;
    logic   r_last;

    logic   w_in_addr;
    logic   w_in_data;
    logic   w_req_ifu;
    logic   w_req_lsu;
    logic   w_any_req;
    logic   w_pick;
    logic   w_gnt_rready;
    logic   w_ar_hs;
    logic   w_r_hs;

    assign w_in_addr = (r_state == ST_ADDR);
    assign w_in_data = (r_state == ST_DATA);

    assign w_req_ifu = ifu_arvalid;
    assign w_req_lsu = lsu_arvalid;
    assign w_any_req = w_req_ifu | w_req_lsu;

    // Under contention the master that was not served last wins; a lone
    // requester always wins regardless of history.
    assign w_pick = (w_req_ifu && w_req_lsu) ? ~r_last : w_req_lsu;

    assign w_gnt_rready = (r_grant == M_LSU) ? lsu_rready : ifu_rready;

    // Handshakes on the SRAM side are what move the FSM; the address phase is
    // driven from state alone, so a master that withdraws arvalid mid-ADDR
    // cannot stall the SRAM transaction.
    assign w_ar_hs = w_in_addr & sram_arready;
    assign w_r_hs  = w_in_data & sram_rvalid & w_gnt_rready;

    // Transaction FSM: arbitrate in IDLE, forward address in ADDR, return data in DATA
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= M_IFU;
            r_last  <= M_IFU;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state <= ST_ADDR;
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                    end
                end
                ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // SRAM-facing request path
    assign sram_arvalid = w_in_addr;
    assign sram_araddr  = (r_grant == M_LSU) ? lsu_araddr : ifu_araddr;
    assign sram_rready  = w_in_data & w_gnt_rready;

    // Only the granted master ever sees arready/rvalid; the other one keeps
    // its request pending until it wins arbitration.
    assign ifu_arready = w_in_addr & (r_grant == M_IFU) & sram_arready;
    assign lsu_arready = w_in_addr & (r_grant == M_LSU) & sram_arready;
    assign ifu_rvalid  = w_in_data & (r_grant == M_IFU) & sram_rvalid;
    assign lsu_rvalid  = w_in_data & (r_grant == M_LSU) & sram_rvalid;

    // Read data and response are broadcast; rvalid identifies the owner
    assign ifu_rdata = sram_rdata;
    assign ifu_rresp = sram_rresp;
    assign lsu_rdata = sram_rdata;
    assign lsu_rresp = sram_rresp;

endmodule

// File: tb/tb_ysyx_23060208_sram_rd_arbiter.sv
// Testbench for ysyx_23060208_sram_rd_arbiter: directed scenarios followed by
// randomized traffic from both masters, with a scoreboard fed at SRAM address
// acceptance and drained when a master takes its read data.
module tb_ysyx_23060208_sram_rd_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] sram_araddr;
    logic        sram_arvalid;
    logic        sram_arready;
    logic [31:0] sram_rdata;
    logic [1:0]  sram_rresp;
    logic        sram_rvalid;
    logic        sram_rready;

    int total = 0;
    int bad   = 0;

    ysyx_23060208_sram_rd_arbiter #(.DATA_WIDTH(32), .RESP_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .sram_araddr(sram_araddr), .sram_arvalid(sram_arvalid), .sram_arready(sram_arready),
        .sram_rdata(sram_rdata), .sram_rresp(sram_rresp), .sram_rvalid(sram_rvalid), .sram_rready(sram_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] outs;
    assign outs = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, sram_arvalid, sram_rready};

    // Memory contents as seen by the SRAM model
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- SRAM model ----------------
    int          ar_pct    = 100;
    int          r_lat_max = 0;
    logic        s_busy;
    logic [31:0] s_addr;
    int          s_wait;

    always @(posedge clk or posedge rst) begin
        int lat;
        if (rst) begin
            sram_arready <= 1'b0;
            sram_rvalid  <= 1'b0;
            sram_rdata   <= '0;
            sram_rresp   <= '0;
            s_busy       <= 1'b0;
            s_addr       <= '0;
            s_wait       <= 0;
        end else if (!s_busy) begin
            if (sram_arvalid && sram_arready) begin
                lat = $urandom_range(r_lat_max, 0);
                s_busy       <= 1'b1;
                s_addr       <= sram_araddr;
                sram_arready <= 1'b0;
                if (lat == 0) begin
                    sram_rvalid <= 1'b1;
                    sram_rdata  <= mem_f(sram_araddr);
                    sram_rresp  <= sram_araddr[3:2];
                end else begin
                    s_wait <= lat;
                end
            end else begin
                sram_arready <= ($urandom_range(99, 0) < ar_pct);
            end
        end else if (sram_rvalid) begin
            if (sram_rready) begin
                sram_rvalid  <= 1'b0;
                s_busy       <= 1'b0;
                sram_arready <= ($urandom_range(99, 0) < ar_pct);
            end
        end else if (s_wait <= 1) begin
            sram_rvalid <= 1'b1;
            sram_rdata  <= mem_f(s_addr);
            sram_rresp  <= s_addr[3:2];
        end else begin
            s_wait <= s_wait - 1;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit          who;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        q[$];
    logic [31:0] addr_log[$];
    bit          grant_log[$];
    bit          m_last, m_owner, m_busy;
    bit          prev_i, prev_l, prev_sarv;

    task automatic pop_check(input bit who, input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        if (q.size() == 0) begin
            fail_now("resp_unexpected");
        end else begin
            e = q.pop_front();
            chk("resp_owner", 64'(who), 64'(e.who));
            chk("resp_data", 64'(d), 64'(e.data));
            chk("resp_resp", 64'(r), 64'(e.resp));
        end
    endtask

    always @(negedge clk or posedge rst) begin
        bit          own;
        logic [31:0] a;
        logic [4:0]  ev;
        exp_t        e;
        if (rst) begin
            q.delete();
            m_last    = 1'b0;
            m_owner   = 1'b0;
            m_busy    = 1'b0;
            prev_i    = 1'b0;
            prev_l    = 1'b0;
            prev_sarv = 1'b0;
        end else begin
            // A new address phase means arbitration happened on the requests
            // that were pending during the previous cycle.
            if (sram_arvalid && !prev_sarv) begin
                if (!prev_i && !prev_l) begin
                    fail_now("spurious_grant");
                end else begin
                    own     = (prev_i && prev_l) ? ~m_last : prev_l;
                    m_owner = own;
                    m_last  = own;
                    m_busy  = 1'b1;
                    chk("grant_addr", 64'(sram_araddr), 64'(own ? lsu_araddr : ifu_araddr));
                end
            end
            ev[4] = m_busy && sram_arvalid && !m_owner && sram_arready;
            ev[3] = m_busy && sram_arvalid &&  m_owner && sram_arready;
            ev[2] = m_busy && !sram_arvalid && !m_owner && sram_rvalid;
            ev[1] = m_busy && !sram_arvalid &&  m_owner && sram_rvalid;
            ev[0] = m_busy && !sram_arvalid && (m_owner ? lsu_rready : ifu_rready);
            chk("hs_signals", 64'({ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, sram_rready}), 64'(ev));
            if (sram_arvalid && sram_arready) begin
                a      = m_owner ? lsu_araddr : ifu_araddr;
                e.who  = m_owner;
                e.data = mem_f(a);
                e.resp = a[3:2];
                q.push_back(e);
                addr_log.push_back(sram_araddr);
                grant_log.push_back(lsu_arready);
            end
            if (ifu_rvalid && ifu_rready) pop_check(1'b0, ifu_rdata, ifu_rresp);
            if (lsu_rvalid && lsu_rready) pop_check(1'b1, lsu_rdata, lsu_rresp);
            if (sram_rvalid && sram_rready) m_busy = 1'b0;
            prev_i    = ifu_arvalid;
            prev_l    = lsu_arvalid;
            prev_sarv = sram_arvalid;
        end
    end

    // ---------------- master driver ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_one(input bit who, input logic [31:0] addr);
        bit done;
        if (who) begin lsu_araddr = addr; lsu_arvalid = 1'b1; end
        else     begin ifu_araddr = addr; ifu_arvalid = 1'b1; end
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (who ? (lsu_arvalid && lsu_arready) : (ifu_arvalid && ifu_arready)) done = 1'b1;
            @(posedge clk); #1;
        end
        if (who) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
        if (!done) fail_now(who ? "lsu_ar_wait" : "ifu_ar_wait");
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (who ? (lsu_rvalid && lsu_rready) : (ifu_rvalid && ifu_rready)) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) fail_now(who ? "lsu_r_wait" : "ifu_r_wait");
    endtask

    task automatic run_master(input bit who, input int n);
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
            a = (who ? 32'h8000_1000 : 32'h8000_0000) + ({22'd0, 8'($urandom_range(255, 0)), 2'b00});
            run_one(who, a);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    bit stop_rr;

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) chk("reset_outs", 64'(outs), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk) chk("first_cycle_outs", 64'(outs), 64'd0);

        // Single IFU read, minimum latency
        @(posedge clk); #1;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        @(negedge clk) chk("t1_arready_c1", 64'(ifu_arready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_arready_c2", 64'(ifu_arready), 64'd1);
        chk("t1_lsu_arready", 64'(lsu_arready), 64'd0);
        chk("t1_sram_araddr", 64'(sram_araddr), 64'h8000_0000);
        @(posedge clk); #1 ifu_arvalid = 1'b0;
        @(negedge clk);
        chk("t1_rvalid", 64'(ifu_rvalid), 64'd1);
        chk("t1_rdata", 64'(ifu_rdata), 64'h0000_0413);
        chk("t1_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk) chk("t1_done", 64'(ifu_rvalid), 64'd0);
        @(posedge clk); #1;

        // Simultaneous requests right after reset: LSU first
        do_reset();
        addr_log.delete();
        fork
            run_one(1'b0, 32'h8000_0000);
            run_one(1'b1, 32'h8000_1000);
        join
        chk("t2_count", 64'(addr_log.size()), 64'd2);
        chk("t2_first", (addr_log.size() > 0) ? 64'(addr_log[0]) : 64'hDEAD, 64'h8000_1000);
        chk("t2_second", (addr_log.size() > 1) ? 64'(addr_log[1]) : 64'hDEAD, 64'h8000_0000);

        // Continuous contention alternates LSU, IFU, ...
        grant_log.delete();
        fork
            begin for (int k = 0; k < 3; k++) run_one(1'b1, 32'h8000_1008 + 32'(k * 4)); end
            begin for (int k = 0; k < 3; k++) run_one(1'b0, 32'h8000_0008 + 32'(k * 4)); end
        join
        for (int i = 0; i < 6; i++)
            chk("t3_grant", (i < grant_log.size()) ? 64'(grant_log[i]) : 64'hDEAD, (i % 2 == 0) ? 64'd1 : 64'd0);

        // IFU stalls rready in DATA while LSU waits
        ifu_araddr = 32'h8000_0010; ifu_arvalid = 1'b1; ifu_rready = 1'b0;
        @(posedge clk); #1;
        lsu_araddr = 32'h8000_1004; lsu_arvalid = 1'b1; lsu_rready = 1'b1;
        @(negedge clk) chk("t4_arready", 64'(ifu_arready), 64'd1);
        @(posedge clk); #1 ifu_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_hold_rvalid", 64'(ifu_rvalid), 64'd1);
            chk("t4_hold_rdata", 64'(ifu_rdata), 64'(mem_f(32'h8000_0010)));
            chk("t4_lsu_blocked", 64'(lsu_arready), 64'd0);
            @(posedge clk); #1;
        end
        ifu_rready = 1'b1;
        @(negedge clk) chk("t4_release", 64'(ifu_rvalid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk) chk("t4_idle", 64'({ifu_rvalid, lsu_arready}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk) chk("t4_lsu_grant", 64'(lsu_arready), 64'd1);
        @(posedge clk); #1 lsu_arvalid = 1'b0;
        @(negedge clk);
        chk("t4_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
        chk("t4_lsu_rdata", 64'(lsu_rdata), 64'(mem_f(32'h8000_1004)));
        @(posedge clk); #1;

        // SRAM address stall
        ar_pct = 0;
        ifu_araddr = 32'h8000_0020; ifu_arvalid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_stall_arready", 64'(ifu_arready), 64'd0);
            chk("t5_stall_addr", 64'(sram_arvalid), 64'd1);
            @(posedge clk); #1;
        end
        ar_pct = 100;
        @(negedge clk) chk("t5_still_addr", 64'({sram_arvalid, ifu_arready}), 64'b10);
        @(posedge clk); #1;
        @(negedge clk) chk("t5_arready", 64'(ifu_arready), 64'd1);
        @(posedge clk); #1 ifu_arvalid = 1'b0;
        @(negedge clk) chk("t5_rdata", 64'({ifu_rvalid, ifu_rdata}), {31'd0, 1'b1, mem_f(32'h8000_0020)});
        @(posedge clk); #1;

        // Reset during DATA, then a fresh minimum-latency read
        ifu_araddr = 32'h8000_0030; ifu_arvalid = 1'b1; ifu_rready = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (ifu_rvalid) seen = 1'b1;
            end
            if (!seen) fail_now("t6_reach_data");
        end
        #2 rst = 1'b1;
        #1 chk("t6_async_reset", 64'(outs), 64'd0);
        ifu_arvalid = 1'b0; ifu_rready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk) chk("t6_post_reset", 64'(outs), 64'd0);
        @(posedge clk); #1;
        ifu_araddr = 32'h8000_0040; ifu_arvalid = 1'b1;
        @(negedge clk) chk("t6_c1", 64'(ifu_arready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk) chk("t6_c2", 64'(ifu_arready), 64'd1);
        @(posedge clk); #1 ifu_arvalid = 1'b0;
        @(negedge clk) chk("t6_c3", 64'({ifu_rvalid, ifu_rdata}), {31'd0, 1'b1, mem_f(32'h8000_0040)});
        @(posedge clk); #1;

        // Randomized traffic from both masters with SRAM and master stalls
        ar_pct = 70;
        r_lat_max = 3;
        stop_rr = 1'b0;
        fork
            begin
                fork
                    run_master(1'b0, 40);
                    run_master(1'b1, 40);
                join
                stop_rr = 1'b1;
            end
            begin
                while (!stop_rr) begin
                    @(posedge clk); #1;
                    ifu_rready = ($urandom_range(3, 0) != 0);
                    lsu_rready = ($urandom_range(3, 0) != 0);
                end
            end
        join
        ifu_rready = 1'b1;
        lsu_rready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk) chk("queue_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
